ps2_mouse_packet: RTL and testbench



---
 rtl/ps2_mouse_packet.sv | 191 +++++++++++++++++++
 tb/tb_ps2_mouse_packet.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packet.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_packet
//  Brief    : Assembles 3-byte PS/2 stream-mode mouse packets into signed
//             screen-oriented dx/dy deltas plus button state, with resync on
//             bad status bytes, inter-byte timeout and receiver errors.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_packet #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int INVERT_Y       = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic       rx_error,
   output logic       new_data,
   output logic [7:0] dx,
   output logic [7:0] dy,
   output logic [2:0] buttons,
   output logic       sync_err
);

   // +1 keeps the counter at least one bit wide for tiny timeouts
   localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit c_INVERT = (INVERT_Y != 0);

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_CNT_W-1:0]   w_cnt_next;

   // Status-byte fields kept from byte 0 (bit 3 is the fixed sync marker)
   logic [2:0]           r_btn;
   logic                 r_xs;
   logic                 r_ys;
   logic                 r_xo;
   logic                 r_yo;
   logic [7:0]           r_xbyte;

   logic                 w_load_status;
   logic                 w_load_x;
   logic                 w_decode;
   logic                 w_sync_err;

   logic signed [9:0]    w_x10;
   logic signed [9:0]    w_y10_raw;
   logic signed [9:0]    w_y10;
   logic                 w_y_neg;
   logic [7:0]           w_dx;
   logic [7:0]           w_dy;

   // Saturate a 10-bit signed value into the signed 8-bit range
   function automatic logic [7:0] clamp8(input logic signed [9:0] v);
      if (v > 10'sd127) begin
         return 8'h7F;
      end else if (v < -10'sd128) begin
         return 8'h80;
      end else begin
         return v[7:0];
      end
   endfunction

   // Packet state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= WAIT_B0;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: rx_error beats byte_valid, which beats timeout
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_load_status = 1'b0;
      w_load_x      = 1'b0;
      w_decode      = 1'b0;
      w_sync_err    = 1'b0;
      if (rx_error) begin
         w_state_next = WAIT_B0;
         w_cnt_next   = '0;
         w_sync_err   = (r_state != WAIT_B0);
      end else if (byte_valid) begin
         w_cnt_next = '0;
         case (r_state)
            WAIT_B0: begin
               if (byte_data[3]) begin
                  w_load_status = 1'b1;
                  w_state_next  = WAIT_B1;
               end else begin
                  w_sync_err = 1'b1;
               end
            end
            WAIT_B1: begin
               w_load_x     = 1'b1;
               w_state_next = WAIT_B2;
            end
            WAIT_B2: begin
               w_decode     = 1'b1;
               w_state_next = WAIT_B0;
            end
            default: begin
               w_state_next = WAIT_B0;
            end
         endcase
      end else if (r_state != WAIT_B0) begin
         if (r_cnt == c_TIMEOUT_LAST) begin
            w_state_next = WAIT_B0;
            w_cnt_next   = '0;
            w_sync_err   = 1'b1;
         end else begin
            w_cnt_next = r_cnt + 1'b1;
         end
      end
   end

   // Delta decode: Y byte is taken straight from the bus on its strobe
   always_comb begin
      w_x10     = {r_xs, r_xs, r_xbyte};
      w_y10_raw = {r_ys, r_ys, byte_data};
      w_y10     = c_INVERT ? (10'sd0 - w_y10_raw) : w_y10_raw;
      w_y_neg   = r_ys ^ c_INVERT;
      if (r_xo) begin
         w_dx = r_xs ? 8'h80 : 8'h7F;
      end else begin
         w_dx = clamp8(w_x10);
      end
      if (r_yo) begin
         w_dy = w_y_neg ? 8'h80 : 8'h7F;
      end else begin
         w_dy = clamp8(w_y10);
      end
   end

   // Timeout counter and captured packet bytes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_btn   <= '0;
         r_xs    <= 1'b0;
         r_ys    <= 1'b0;
         r_xo    <= 1'b0;
         r_yo    <= 1'b0;
         r_xbyte <= '0;
      end else begin
         r_cnt <= w_cnt_next;
         if (w_load_status) begin
            r_btn <= byte_data[2:0];
            r_xs  <= byte_data[4];
            r_ys  <= byte_data[5];
            r_xo  <= byte_data[6];
            r_yo  <= byte_data[7];
         end
         if (w_load_x) begin
            r_xbyte <= byte_data;
         end
      end
   end

   // Registered outputs: deltas hold between packets, strobes last one cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         new_data <= 1'b0;
         sync_err <= 1'b0;
         dx       <= '0;
         dy       <= '0;
         buttons  <= '0;
      end else begin
         new_data <= w_decode;
         sync_err <= w_sync_err;
         if (w_decode) begin
            dx      <= w_dx;
            dy      <= w_dy;
            buttons <= r_btn;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_packet.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_mouse_packet
//  Brief    : Self-checking bench for ps2_mouse_packet (table of packets plus
//             sync, timeout, rx_error and reset sequences, scoreboard queue).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_packet;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       rx_error;
   logic       new_data;
   logic [7:0] dx;
   logic [7:0] dy;
   logic [2:0] buttons;
   logic       sync_err;

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] dx;
      logic [7:0] dy;
      logic [2:0] btn;
   } vec_t;

   vec_t        tbl [0:9];
   logic [18:0] exp_q[$];
   logic [18:0] act_q[$];
   int          rd        = 0;
   int          act_sync  = 0;
   int          exp_sync  = 0;
   int          overlap   = 0;
   int          n_cmp     = 0;
   int          n_bad     = 0;

   ps2_mouse_packet #(
      .TIMEOUT_CYCLES (TO),
      .INVERT_Y       (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .rx_error   (rx_error),
      .new_data   (new_data),
      .dx         (dx),
      .dy         (dy),
      .buttons    (buttons),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   // Monitor: record every decoded packet and sync_err pulse
   always @(negedge clk) begin
      if (new_data) act_q.push_back({dx, dy, buttons});
      if (sync_err) act_sync++;
      if (new_data && sync_err) overlap++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic err);
      byte_valid = 1'b1;
      byte_data  = b;
      rx_error   = err;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      rx_error   = 1'b0;
      byte_data  = 8'h00;
   endtask

   task automatic send_pkt(input vec_t v);
      exp_q.push_back({v.dx, v.dy, v.btn});
      send_byte(v.b0, 1'b0);
      send_byte(v.b1, 1'b0);
      send_byte(v.b2, 1'b0);
      check("new_data latency", 32'(new_data), 32'd1);
   endtask

   // Compare every captured packet against the scoreboard
   task automatic drain();
      logic [18:0] e;
      tick(2);
      while (rd < act_q.size()) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected new_data: got %h expected none", act_q[rd]);
         end else begin
            e = exp_q.pop_front();
            check("packet {dx,dy,btn}", 32'(act_q[rd]), 32'(e));
         end
         rd++;
      end
      check("missing new_data", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      reset_n    = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      rx_error   = 1'b0;

      tbl[0] = '{8'h09, 8'h05, 8'h03, 8'h05, 8'hFD, 3'b001};
      tbl[1] = '{8'h38, 8'hFB, 8'hFE, 8'hFB, 8'h02, 3'b000};
      tbl[2] = '{8'h48, 8'h10, 8'h00, 8'h7F, 8'h00, 3'b000};
      tbl[3] = '{8'h58, 8'h10, 8'h00, 8'h80, 8'h00, 3'b000};
      tbl[4] = '{8'h38, 8'h00, 8'h00, 8'h80, 8'h7F, 3'b000};
      tbl[5] = '{8'h88, 8'h00, 8'h05, 8'h00, 8'h80, 3'b000};
      tbl[6] = '{8'h0F, 8'h7F, 8'h80, 8'h7F, 8'h80, 3'b111};
      tbl[7] = '{8'h18, 8'h80, 8'h00, 8'h80, 8'h00, 3'b000};
      tbl[8] = '{8'h28, 8'h00, 8'h81, 8'h00, 8'h7F, 3'b000};
      tbl[9] = '{8'hC8, 8'h00, 8'h00, 8'h7F, 8'h80, 3'b000};

      tick(3);
      check("reset outputs", 32'({new_data, dx, dy, buttons, sync_err}), 32'd0);
      reset_n = 1'b1;
      tick(2);

      // Table of packets, sent back-to-back with no gap
      for (int i = 0; i < 10; i++) send_pkt(tbl[i]);
      drain();
      check("sync_err after table", 32'(act_sync), 32'(exp_sync));

      // Byte without sync bit in WAIT_B0 is dropped
      send_byte(8'h05, 1'b0);
      exp_sync++;
      drain();
      check("sync_err bad status", 32'(act_sync), 32'(exp_sync));
      send_pkt('{8'h08, 8'h01, 8'h01, 8'h01, 8'hFF, 3'b000});
      drain();

      // Timeout in WAIT_B2
      send_byte(8'h08, 1'b0);
      send_byte(8'h10, 1'b0);
      tick(TO - 1);
      check("no early timeout", 32'(act_sync), 32'(exp_sync));
      tick(1);
      exp_sync++;
      drain();
      check("sync_err timeout B2", 32'(act_sync), 32'(exp_sync));
      send_pkt('{8'h08, 8'h02, 8'h00, 8'h02, 8'h00, 3'b000});
      drain();

      // Timeout in WAIT_B1
      send_byte(8'h08, 1'b0);
      tick(TO);
      exp_sync++;
      drain();
      check("sync_err timeout B1", 32'(act_sync), 32'(exp_sync));

      // Byte landing on the expiry cycle continues the packet
      send_byte(8'h08, 1'b0);
      send_byte(8'h10, 1'b0);
      tick(TO - 1);
      exp_q.push_back({8'h10, 8'hFB, 3'b000});
      send_byte(8'h05, 1'b0);
      check("expiry-cycle byte latency", 32'(new_data), 32'd1);
      drain();
      check("no sync_err on expiry byte", 32'(act_sync), 32'(exp_sync));

      // rx_error after byte 1 (with byte_valid also high)
      send_byte(8'h08, 1'b0);
      send_byte(8'h00, 1'b1);
      exp_sync++;
      send_pkt('{8'h09, 8'h03, 8'h00, 8'h03, 8'h00, 3'b001});
      drain();
      check("sync_err rx_error B1", 32'(act_sync), 32'(exp_sync));

      // rx_error in WAIT_B0: byte ignored, no pulse
      send_byte(8'h08, 1'b1);
      send_pkt('{8'h0A, 8'h04, 8'h04, 8'h04, 8'hFC, 3'b010});
      drain();
      check("no sync_err rx_error B0", 32'(act_sync), 32'(exp_sync));

      // Asynchronous reset after byte 2
      send_byte(8'h0F, 1'b0);
      send_byte(8'h7F, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset outputs", 32'({new_data, dx, dy, buttons, sync_err}), 32'd0);
      tick(1);
      reset_n = 1'b1;
      tick(1);
      send_byte(8'h08, 1'b0);
      send_byte(8'h03, 1'b0);
      drain();
      exp_q.push_back({8'h03, 8'hF9, 3'b000});
      send_byte(8'h07, 1'b0);
      check("post-reset packet latency", 32'(new_data), 32'd1);
      drain();
      check("sync_err after reset", 32'(act_sync), 32'(exp_sync));

      check("new_data/sync_err overlap", 32'(overlap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
